serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract controller: accepts two WIDTH-bit operands over a valid/ready handshake.
- Sequences a single 1-bit full-adder slice LSB-first, one bit per clock, holding the carry in a flop between bits.
- Presents the result, carry and signed overflow over an output valid/ready handshake.
- Sits between the operand source and the result consumer. It is the sequencer that time-shares the library's 1-bit gate/adder cell instead of a WIDTH-bit ripple chain.

---
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice reused LSB-first,
// with valid/ready handshakes on the operand and result sides.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic sumBit;
    logic cOut;

    // The single shared full-adder slice; subtraction arrives pre-inverted with carry-in = 1.
    assign sumBit = sa_q[0] ^ sb_q[0] ^ c_q;
    assign cOut   = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        c_d       = c_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b ^ {WIDTH{sub}};
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {sumBit, res_q[WIDTH-1:1]};
                c_d   = cOut;
                cnt_d = cnt_q + CNT_W'(1);
                // On the MSB, c_q is the carry into it and cOut the carry out of it.
                if (cnt_q == LAST_BIT) begin
                    ovf_d   = c_q ^ cOut;
                    carry_d = cOut;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum       = res_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed WIDTH=8 cases plus an
// exhaustive WIDTH=4 sweep, both scored against an arithmetic reference model.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    logic       inValid8, inReady8, sub8, busy8, outValid8, outReady8, carry8, ovf8;
    logic [7:0] a8, b8, sum8;

    logic       inValid4, inReady4, sub4, busy4, outValid4, outReady4, carry4, ovf4;
    logic [3:0] a4, b4, sum4;

    int vectors;
    int miscompares;

    logic [33:0] expQ8[$];
    logic [33:0] expQ4[$];

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid8), .in_ready(inReady8),
        .a(a8), .b(b8), .sub(sub8),
        .busy(busy8),
        .out_valid(outValid8), .out_ready(outReady8),
        .sum(sum8), .carry_out(carry8), .overflow(ovf8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(inValid4), .in_ready(inReady4),
        .a(a4), .b(b4), .sub(sub4),
        .busy(busy4),
        .out_valid(outValid4), .out_ready(outReady4),
        .sum(sum4), .carry_out(carry4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {overflow, carry, sum} computed with plain wide arithmetic and sign rules.
    function automatic logic [33:0] refModel(input int w, input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic [63:0] mask, bb, ext;
        logic [31:0] sm;
        logic        c, o, sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        bb   = (s ? ~{32'b0, b} : {32'b0, b}) & mask;
        ext  = ({32'b0, a} & mask) + bb + {63'b0, s};
        sm   = ext[31:0] & mask[31:0];
        c    = ext[w];
        sa   = a[w-1];
        sb   = b[w-1];
        sr   = sm[w-1];
        o    = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        return {o, c, sm};
    endfunction

    task automatic checkOutput(input string tag, input logic [33:0] observed, input logic [33:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s);
        bit accepted;
        accepted = 1'b0;
        a8 = a;
        b8 = b;
        sub8 = s;
        inValid8 = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            if (inReady8) begin
                expQ8.push_back(refModel(8, {24'b0, a}, {24'b0, b}, s));
                accepted = 1'b1;
            end
            @(posedge clk); #1;
        end
        inValid8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        sub8 = 1'($urandom);
        if (!accepted) checkOutput("accept_timeout", 34'd0, 34'd1);
    endtask

    task automatic waitResult8(input string tag, input bit checkLatency);
        int          n;
        logic [33:0] e;
        n = 0;
        while (!outValid8 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (checkLatency) checkOutput({tag, "_latency"}, 34'(n), 34'd8);
        if (!outValid8) begin
            checkOutput({tag, "_result_timeout"}, 34'd0, 34'd1);
        end else begin
            checkOutput({tag, "_inReady_in_done"}, {33'b0, inReady8}, 34'd0);
            if (expQ8.size() == 0) begin
                checkOutput({tag, "_queue_empty"}, 34'd0, 34'd1);
            end else begin
                e = expQ8.pop_front();
                checkOutput({tag, "_sum"}, {26'b0, sum8}, {26'b0, e[7:0]});
                checkOutput({tag, "_carry"}, {33'b0, carry8}, {33'b0, e[32]});
                checkOutput({tag, "_ovf"}, {33'b0, ovf8}, {33'b0, e[33]});
            end
        end
    endtask

    initial begin
        logic [33:0] e;
        bit          ok;
        int          n;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        inValid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; outReady8 = 1'b1;
        inValid4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0; outReady4 = 1'b1;

        #23;
        checkOutput("rst_inReady", {33'b0, inReady8}, 34'd1);
        checkOutput("rst_busy", {33'b0, busy8}, 34'd0);
        checkOutput("rst_outValid", {33'b0, outValid8}, 34'd0);
        checkOutput("rst_sum", {26'b0, sum8}, 34'd0);
        checkOutput("rst_carry", {33'b0, carry8}, 34'd0);
        checkOutput("rst_ovf", {33'b0, ovf8}, 34'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8'h0F, 8'h01, 1'b0);
        checkOutput("run_busy", {33'b0, busy8}, 34'd1);
        waitResult8("add_0F_01", 1'b1);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitResult8("add_FF_01", 1'b1);
        applyStimulus(8'h7F, 8'h01, 1'b0);
        waitResult8("add_7F_01", 1'b0);
        applyStimulus(8'h05, 8'h07, 1'b1);
        waitResult8("sub_05_07", 1'b1);
        applyStimulus(8'h80, 8'h01, 1'b1);
        waitResult8("sub_80_01", 1'b0);

        // Backpressure: result must hold while new operands wait on in_valid.
        @(posedge clk); #1;
        outReady8 = 1'b0;
        applyStimulus(8'h33, 8'h22, 1'b0);
        waitResult8("bp_first", 1'b1);
        e = refModel(8, 32'h33, 32'h22, 1'b0);
        a8 = 8'h11; b8 = 8'h11; sub8 = 1'b0; inValid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_outValid", {33'b0, outValid8}, 34'd1);
            checkOutput("bp_inReady", {33'b0, inReady8}, 34'd0);
            checkOutput("bp_sum_stable", {26'b0, sum8}, {26'b0, e[7:0]});
        end
        outReady8 = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_idle_outValid", {33'b0, outValid8}, 34'd0);
        checkOutput("bp_idle_inReady", {33'b0, inReady8}, 34'd1);
        applyStimulus(8'h11, 8'h11, 1'b0);
        waitResult8("bp_second", 1'b1);

        // Asynchronous reset while the slice is on bit 3.
        applyStimulus(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid_busy_before", {33'b0, busy8}, 34'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", {33'b0, busy8}, 34'd0);
        checkOutput("mid_outValid", {33'b0, outValid8}, 34'd0);
        checkOutput("mid_sum", {26'b0, sum8}, 34'd0);
        checkOutput("mid_inReady", {33'b0, inReady8}, 34'd1);
        expQ8.delete();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(8'h12, 8'h34, 1'b0);
        waitResult8("post_reset_12_34", 1'b1);

        // Exhaustive sweep on the 4-bit instance.
        for (int s = 0; s < 2; s++) begin
            for (int ai = 0; ai < 16; ai++) begin
                for (int bi = 0; bi < 16; bi++) begin
                    a4 = ai[3:0]; b4 = bi[3:0]; sub4 = s[0]; inValid4 = 1'b1;
                    ok = 1'b0;
                    for (int i = 0; i < 20 && !ok; i++) begin
                        if (inReady4) begin
                            expQ4.push_back(refModel(4, 32'(ai), 32'(bi), s[0]));
                            ok = 1'b1;
                        end
                        @(posedge clk); #1;
                    end
                    inValid4 = 1'b0;
                    if (!ok) checkOutput("w4_accept_timeout", 34'd0, 34'd1);
                    n = 0;
                    while (!outValid4 && n < 20) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (!outValid4 || expQ4.size() == 0) begin
                        checkOutput("w4_result_timeout", 34'd0, 34'd1);
                    end else begin
                        e = expQ4.pop_front();
                        checkOutput("w4_handshake", {32'b0, inReady4, busy4}, 34'd0);
                        checkOutput($sformatf("w4_s%0d_%0h_%0h", s, ai, bi),
                                    {carry4, ovf4, 28'b0, sum4}, {e[32], e[33], 28'b0, e[3:0]});
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
